// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and types for the round-robin arbiter
package arb_pkg;

  localparam int N_DEF     = 8;
  localparam int CNT_W_DEF = 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef logic [N_DEF-1:0] onehot_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority winner search
module rr_pick
  import arb_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     win,
  output logic [IDX_W-1:0] win_idx
);

  logic [2*N-1:0] dbl;
  logic           found;
  int             sum;

  // Rotating the doubled vector right by ptr puts the highest-priority bit at 0.
  assign dbl = {req, req} >> ptr;

  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    sum     = 0;
    for (int k = 0; k < N; k++) begin
      if (!found && dbl[k]) begin
        found = 1'b1;
        sum   = int'(ptr) + k;
        if (sum >= N) sum = sum - N;
        win_idx = IDX_W'(sum);
      end
    end
    win = found ? (N'(1) << win_idx) : '0;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - round-robin arbiter with registered one-hot grant held until done
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     gnt,
  output logic             gnt_valid,
  output logic [CNT_W-1:0] gnt_cnt
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [CNT_W-1:0] gnt_cnt_q, gnt_cnt_d;

  logic [N-1:0]     win;
  logic [IDX_W-1:0] win_idx;
  logic             arbitrate;

  rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .win     (win),
    .win_idx (win_idx)
  );

  // A new decision is taken when idle, or when the consumer releases the grant.
  assign arbitrate = (state_q == ST_IDLE) || done;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    gnt_cnt_d = gnt_cnt_q;
    if (arbitrate) begin
      if (|req) begin
        state_d   = ST_BUSY;
        gnt_d     = win;
        ptr_d     = (int'(win_idx) == N - 1) ? '0 : win_idx + IDX_W'(1);
        gnt_cnt_d = gnt_cnt_q + CNT_W'(1);
      end else begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    end
    gnt_valid_d = |gnt_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_cnt_q   <= gnt_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_cnt   = gnt_cnt_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - scoreboard bench for rr_arbiter_8 against a behavioural model
module tb_rr_arbiter_8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic [7:0] gnt_cnt;

  rr_arbiter_8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_cnt   (gnt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] gnt;
    logic       valid;
    logic [7:0] cnt;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model state: granted index (-1 when none), priority pointer, grant count.
  int m_cur = -1;
  int m_ptr = 0;
  int m_cnt = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, want);
    end
  endtask

  task automatic model_step(input logic [7:0] r, input logic d, input logic rn);
    int w;
    if (!rn) begin
      m_cur = -1;
      m_ptr = 0;
      m_cnt = 0;
    end else if (m_cur < 0 || d) begin
      w = -1;
      for (int k = 0; k < 8; k++) begin
        if (w < 0 && r[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
      end
      if (w >= 0) begin
        m_cur = w;
        m_ptr = (w + 1) % 8;
        m_cnt = (m_cnt + 1) % 256;
      end else begin
        m_cur = -1;
      end
    end
  endtask

  task automatic drive(input logic [7:0] r, input logic d, input logic rn, input string tag);
    exp_t e;
    @(negedge clk);
    req   = r;
    done  = d;
    rst_n = rn;
    model_step(r, d, rn);
    e.gnt   = (m_cur < 0) ? 8'h00 : (8'h01 << m_cur);
    e.valid = (m_cur >= 0);
    e.cnt   = 8'(m_cnt);
    e.tag   = tag;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.tag, ".gnt"}, gnt, e.gnt);
        check({e.tag, ".gnt_valid"}, {7'b0, gnt_valid}, {7'b0, e.valid});
        check({e.tag, ".gnt_cnt"}, gnt_cnt, e.cnt);
        n_cmp++;
        if ($countones(gnt) > 1) begin
          n_bad++;
          $display("FAIL %s.onehot: got %h required at most one bit", e.tag, gnt);
        end
      end
    end
  end

  initial begin : stim
    int budget;
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;

    drive(8'h00, 1'b0, 1'b0, "reset0");
    drive(8'h00, 1'b0, 1'b0, "reset1");
    drive(8'h00, 1'b1, 1'b1, "idle_done");

    drive(8'h04, 1'b0, 1'b1, "single_grant");
    for (int i = 0; i < 4; i++) drive(8'h04, 1'b0, 1'b1, "single_hold");
    drive(8'h00, 1'b1, 1'b1, "single_release");
    drive(8'h08, 1'b0, 1'b1, "ptr_after_single");
    drive(8'h00, 1'b1, 1'b1, "release2");

    drive(8'h00, 1'b0, 1'b0, "reset_rot");
    for (int i = 0; i < 9; i++) drive(8'hFF, 1'b1, 1'b1, "rotation");

    drive(8'h00, 1'b0, 1'b0, "reset_wrap");
    for (int i = 0; i < 8; i++) drive(8'hFF, 1'b1, 1'b1, "serve_all");
    drive(8'h81, 1'b1, 1'b1, "ptr_wrap_first");
    drive(8'h81, 1'b1, 1'b1, "ptr_wrap_second");
    drive(8'h80, 1'b1, 1'b1, "sole_b2b");
    drive(8'h00, 1'b1, 1'b1, "wrap_release");

    drive(8'h20, 1'b0, 1'b1, "grant5");
    for (int i = 0; i < 3; i++) drive(8'h00, 1'b0, 1'b1, "withdraw_hold");
    drive(8'hFF, 1'b1, 1'b0, "mid_grant_reset");
    drive(8'h00, 1'b0, 1'b1, "after_reset");

    for (int i = 0; i < 256; i++) drive(8'hFF, 1'b1, 1'b1, "cnt_wrap");
    drive(8'h00, 1'b1, 1'b1, "cnt_wrap_release");

    for (int i = 0; i < 400; i++) begin
      drive(8'($urandom_range(0, 255)) & ((($urandom % 4) == 0) ? 8'h00 : 8'hFF),
            1'($urandom % 2), ($urandom_range(0, 49) != 0), "random");
    end

    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Eight-input round-robin arbiter that sits directly upstream of the 8-to-3 encoder. It samples eight request lines and issues a registered one-hot grant, which is exactly the one-hot input the encoder consumes. The grant is held until the consumer signals `done`. Rotating priority guarantees every persistent requester is served within N grants.

## Interface
Parameters:
- `N`, 8, number of request lines. The one-hot grant width equals `N`; the downstream encoder requires 8.
- `CNT_W`, 8, width of the grant counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req`  in  N  request lines; bit i high means requester i wants service.
- `done`  in  1  consumer releases the current grant; only meaningful while `gnt_valid`=1.
- `gnt`  out  N  registered one-hot grant, or all-zero when idle.
- `gnt_valid`  out  1  high exactly when `gnt` is non-zero.
- `gnt_cnt`  out  CNT_W  count of grants issued since reset; wraps.

## Operation
- FSM states:
  - IDLE: no grant outstanding.
  - BUSY: a grant is outstanding.
- Priority pointer `ptr` (0..N-1) names the highest-priority index. Search order is ptr, ptr+1, …, N-1, 0, …, ptr-1, modulo N.
- IDLE:
  - If `req`≠0, pick the winner w by rotating search from `ptr`.
  - Register `gnt`=1<<w and go to BUSY.
  - Update `ptr`=(w+1) mod N and increment `gnt_cnt`.
  - If `req`=0, stay in IDLE with `gnt`=0.
- BUSY:
  - Hold `gnt` stable while `done`=0, even if the granted `req` bit drops. Request withdrawal never revokes a grant.
  - On `done`=1 with `req`≠0: pick a new winner from the updated `ptr`, register the new grant and stay BUSY. There is no idle bubble.
  - The just-served index is eligible again only if it is the sole requester (back-to-back grant).
  - On `done`=1 with `req`=0: clear `gnt` and return to IDLE.
- `done` in IDLE is ignored.
- `gnt_cnt` increments by 1 on every new grant, including back-to-back grants. It wraps from 2^CNT_W−1 to 0.
- `gnt` is never multi-hot. `gnt_valid` equals the OR-reduction of registered `gnt`, and is itself registered, not combinational.

## Timing
- Reset, evaluated on a clock edge with `rst_n`=0:
  - state=IDLE, `ptr`=0, `gnt`=0, `gnt_valid`=0, `gnt_cnt`=0.
  - Reset overrides everything, including mid-grant; the grant drops at that edge.
- Grant latency: a `req` sampled at edge k in IDLE produces `gnt`/`gnt_valid` valid after edge k, i.e. one cycle.
- Handover latency: `done` sampled at edge k changes `gnt` after edge k, to either the new one-hot value or zero.
- Downstream encoder output is valid in the same cycle as `gnt_valid`; the encoder is combinational.
- Simultaneous events:
  - `done`=1 and a new `req` bit rising in the same cycle: the new bit participates in arbitration.
  - `rst_n`=0 together with `done`/`req`: reset wins.
- Fairness: with all eight `req` held high and `done` pulsed every cycle, grants cycle 0,1,…,7,0 with no index skipped.

## Structure
- Shared package `arb_pkg` holds:
  - the state encoding (`ST_IDLE`, `ST_BUSY`);
  - default `N`=8 and `CNT_W`=8;
  - a `onehot_t` typedef of width N.
- Sub-module `rr_pick`:
  - purely combinational;
  - inputs `req` and `ptr`; outputs one-hot `win` and index `win_idx`;
  - implemented as a masked-priority/double-width rotate search.
- The top level holds only the FSM, `ptr`, the `gnt` register and `gnt_cnt`.

## Test plan
- Reset then idle:
  - Stimulus: `rst_n`=0 for 2 cycles, `req`=0.
  - Required: `gnt`=8'b0, `gnt_valid`=0, `gnt_cnt`=0 throughout.
- Single request with hold:
  - Stimulus: `req`=8'b00000100; `done`=0 for 5 cycles, then `done`=1 for 1 cycle with `req`=0.
  - Required: `gnt`=8'b00000100 one cycle after `req`, stable for the whole hold; 0 after `done`; `gnt_cnt`=1; `ptr`=3.
- Round-robin rotation:
  - Stimulus: `req`=8'hFF constant, `done`=1 every BUSY cycle.
  - Required: `gnt` sequence 01,02,04,08,10,20,40,80,01 (hex); `gnt_cnt` reaches 9.
- Pointer wrap:
  - Stimulus: after serving index 7 (`ptr`=0), present `req`=8'b10000001.
  - Required: grant to index 0 first, then index 7.
- Withdrawal and mid-grant reset:
  - Stimulus: grant index 5, drop `req[5]` with `done`=0.
  - Required: `gnt` stays 8'b00100000.
  - Stimulus: then assert `rst_n`=0 for one edge.
  - Required: `gnt`=0, `ptr`=0, `gnt_cnt`=0.
- Counter wrap:
  - Stimulus: issue 256 grants.
  - Required: `gnt_cnt` returns to 0.
